// File: rtl/rs_alloc_ctrl.sv
// rs_alloc_ctrl: reservation-station buffer allocation controller.
// Tracks free entries of a WIDTH-entry RS buffer and grants up to three one-hot
// entry selects per cycle (slot 0 = lowest free, slot 1 = highest free,
// slot 2 = second-lowest free). Entries come back via free_en/free_mask or flush.
// Optional feature: define RS_ALLOC_DBLFREE_CHK_EN to enable the sticky dbl_free
// protocol checker; otherwise dbl_free is tied low.
`ifndef RS_BUF_COUNT
`define RS_BUF_COUNT 32
`endif

module rs_alloc_ctrl #(
  parameter int WIDTH = `RS_BUF_COUNT,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc0,
  input  logic             alloc1,
  input  logic             alloc2,
  input  logic             stall,
  input  logic             free_en,
  input  logic [WIDTH-1:0] free_mask,
  input  logic             flush,
  output logic [WIDTH-1:0] newRsSelect0,
  output logic [WIDTH-1:0] newRsSelect1,
  output logic [WIDTH-1:0] newRsSelect2,
  output logic             doStall,
  output logic [CNT_W-1:0] free_count,
  output logic             dbl_free
);

  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  logic [WIDTH-1:0] buf_free;
  logic [WIDTH-1:0] cand0, cand1, cand2, rest;
  logic [WIDTH-1:0] granted, free_vec;
  logic [CNT_W-1:0] grant_cnt, newly_cnt;
  logic             acc, grant0, grant1, grant2;

  function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++)
      if (v[i]) c = c + CNT_ONE;
    return c;
  endfunction

  // Stall depends only on the registered count, so there is no path from alloc*/stall.
  assign doStall = (free_count < CNT_W'(3));

  // Candidate selection from registered free vector: lowest, highest, second-lowest.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    cand1 = '0;
    for (int i = 0; i < WIDTH; i++)
      if (buf_free[i]) cand1 = ONE << i;
    cand0 = buf_free & (~buf_free + ONE);
    rest  = buf_free & ~cand0;
    cand2 = rest & (~rest + ONE);
  end

  // Grant qualification and next-state bookkeeping terms.
  always_comb begin
    acc      = ~doStall & ~stall & ~flush;
    grant0   = acc & alloc0;
    grant1   = acc & alloc1;
    grant2   = acc & alloc2;
    granted  = (grant0 ? cand0 : '0) | (grant1 ? cand1 : '0) | (grant2 ? cand2 : '0);
    free_vec = free_en ? free_mask : '0;
    grant_cnt = '0;
    if (grant0) grant_cnt = grant_cnt + CNT_ONE;
    if (grant1) grant_cnt = grant_cnt + CNT_ONE;
    if (grant2) grant_cnt = grant_cnt + CNT_ONE;
    // Only entries that were not already free add to the count.
    newly_cnt = popcount(free_vec & ~buf_free);
  end

  // Free vector, free count and select registers; flush overrides everything.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst || flush) begin
      buf_free     <= '1;
      free_count   <= CNT_MAX;
      newRsSelect0 <= '0;
      newRsSelect1 <= '0;
      newRsSelect2 <= '0;
    end else begin
      buf_free     <= (buf_free & ~granted) | free_vec;
      free_count   <= free_count - grant_cnt + newly_cnt;
      newRsSelect0 <= grant0 ? cand0 : '0;
      newRsSelect1 <= grant1 ? cand1 : '0;
      newRsSelect2 <= grant2 ? cand2 : '0;
    end
  end

`ifdef RS_ALLOC_DBLFREE_CHK_EN
  // Sticky protocol-error flag: releasing a free entry or one granted this cycle.
  always_ff @(posedge clk) begin
    if (rst)
      dbl_free <= 1'b0;
    else if (free_en && ((free_mask & buf_free) != '0 || (free_mask & granted) != '0))
      dbl_free <= 1'b1;
  end
`else
  assign dbl_free = 1'b0;
`endif

endmodule

// File: tb/tb_rs_alloc_ctrl.sv
// Self-checking bench for rs_alloc_ctrl: directed scenarios plus random traffic,
// with an index-based reference model feeding a scoreboard queue.
module tb_rs_alloc_ctrl;

  localparam int W  = 32;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          alloc0 = 0, alloc1 = 0, alloc2 = 0, stall = 0, free_en = 0, flush = 0;
  logic [W-1:0]  free_mask = '0;
  logic [W-1:0]  sel0, sel1, sel2;
  logic          do_stall, dbl;
  logic [CW-1:0] fcnt;

  rs_alloc_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .alloc0(alloc0), .alloc1(alloc1), .alloc2(alloc2),
    .stall(stall), .free_en(free_en), .free_mask(free_mask), .flush(flush),
    .newRsSelect0(sel0), .newRsSelect1(sel1), .newRsSelect2(sel2),
    .doStall(do_stall), .free_count(fcnt), .dbl_free(dbl)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           due;
    logic [W-1:0] s0, s1, s2;
    int           cnt;
    logic         stl;
    logic         dbl;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  // Reference model state: which entries are free, and the sticky error flag.
  bit   m_free[W];
  bit   m_dbl;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < W; i++) c += m_free[i];
    return c;
  endfunction

  function automatic int lowest(input int skip);
    for (int i = 0; i < W; i++) if (m_free[i] && i != skip) return i;
    return -1;
  endfunction

  function automatic int highest();
    for (int i = W - 1; i >= 0; i--) if (m_free[i]) return i;
    return -1;
  endfunction

  function automatic logic [W-1:0] onehot(input int idx);
    logic [W-1:0] r = '0;
    if (idx >= 0) r[idx] = 1'b1;
    return r;
  endfunction

  function automatic logic [W-1:0] allocated_mask();
    logic [W-1:0] r = '0;
    for (int i = 0; i < W; i++) r[i] = ~m_free[i];
    return r;
  endfunction

  // Drive one cycle of inputs, run the model, queue the expected post-edge response.
  task automatic step(input bit r, input bit a0, input bit a1, input bit a2, input bit st,
                      input bit fe, input logic [W-1:0] fm, input bit fl);
    exp_t e;
    int   lo, hi, lo2;
    bit   acc, g0, g1, g2;
    @(posedge clk);
    #1;
    rst = r; alloc0 = a0; alloc1 = a1; alloc2 = a2; stall = st;
    free_en = fe; free_mask = fm; flush = fl;
    e.due = cyc + 1;
    e.s0 = '0; e.s1 = '0; e.s2 = '0;
    lo = lowest(-1); hi = highest(); lo2 = lowest(lo);
    acc = (m_count() >= 3) && !st && !fl && !r;
    g0 = acc && a0; g1 = acc && a1; g2 = acc && a2;
    if (r) begin
      for (int i = 0; i < W; i++) m_free[i] = 1'b1;
      m_dbl = 1'b0;
    end else begin
`ifdef RS_ALLOC_DBLFREE_CHK_EN
      if (fe) for (int i = 0; i < W; i++)
        if (fm[i] && (m_free[i] || (g0 && i == lo) || (g1 && i == hi) || (g2 && i == lo2)))
          m_dbl = 1'b1;
`endif
      if (fl) begin
        for (int i = 0; i < W; i++) m_free[i] = 1'b1;
      end else begin
        if (g0) begin e.s0 = onehot(lo);  m_free[lo]  = 1'b0; end
        if (g1) begin e.s1 = onehot(hi);  m_free[hi]  = 1'b0; end
        if (g2) begin e.s2 = onehot(lo2); m_free[lo2] = 1'b0; end
        if (fe) for (int i = 0; i < W; i++) if (fm[i]) m_free[i] = 1'b1;
      end
    end
    e.cnt = m_count();
    e.stl = (e.cnt < 3);
    e.dbl = m_dbl;
    q.push_back(e);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, '0, 0);
  endtask

  // Monitor: compare DUT outputs against queued expectations once they are due.
  always @(negedge clk) begin
    if (q.size() > 0 && q[0].due <= cyc) begin
      exp_t e;
      e = q.pop_front();
      check("sel0",       64'(sel0),     64'(e.s0));
      check("sel1",       64'(sel1),     64'(e.s1));
      check("sel2",       64'(sel2),     64'(e.s2));
      check("free_count", 64'(fcnt),     64'(e.cnt));
      check("doStall",    64'(do_stall), 64'(e.stl));
      check("dbl_free",   64'(dbl),      64'(e.dbl));
    end
  end

  initial begin
    for (int i = 0; i < W; i++) m_free[i] = 1'b1;
    m_dbl = 1'b0;

    // Reset state, then a full three-slot group on a fresh buffer.
    step(1, 0, 0, 0, 0, 0, '0, 0);
    step(1, 0, 0, 0, 0, 0, '0, 0);
    step(0, 1, 1, 1, 0, 0, '0, 0);
    idle();

    // Lone alloc1 gets the highest entry.
    step(1, 0, 0, 0, 0, 0, '0, 0);
    step(0, 0, 1, 0, 0, 0, '0, 0);
    idle();

    // Drain to two free entries, hit back-pressure, then release entry 0.
    step(1, 0, 0, 0, 0, 0, '0, 0);
    for (int k = 0; k < 12; k++) step(0, 1, 1, 1, 0, 0, '0, 0);
    step(0, 1, 1, 1, 0, 1, 32'h1, 0);
    step(0, 1, 1, 1, 0, 0, '0, 0);
    idle();

    // External stall holds grants; release it and grants resume.
    step(1, 0, 0, 0, 0, 0, '0, 0);
    step(0, 1, 1, 1, 1, 0, '0, 0);
    step(0, 1, 1, 1, 1, 0, '0, 0);
    step(0, 1, 1, 1, 0, 0, '0, 0);

    // Flush with allocs pending cancels the grants and refills the buffer.
    step(1, 0, 0, 0, 0, 0, '0, 0);
    step(0, 1, 1, 1, 0, 0, '0, 0);
    step(0, 1, 1, 1, 0, 0, '0, 0);
    step(0, 1, 1, 1, 0, 0, '0, 1);
    step(0, 1, 1, 1, 0, 0, '0, 0);

    // Release an entry that is already free; flag survives a flush.
    step(0, 0, 0, 0, 0, 1, 32'h20, 0);
    step(0, 0, 0, 0, 0, 0, '0, 1);
    idle();
    step(1, 0, 0, 0, 0, 0, '0, 0);

    // Random traffic; frees only target allocated entries so they never clash with grants.
    for (int k = 0; k < 400; k++) begin
      bit r, fl, st, fe;
      r  = ($urandom_range(0, 149) == 0);
      fl = ($urandom_range(0, 39) == 0);
      st = ($urandom_range(0, 7) == 0);
      fe = ($urandom_range(0, 2) == 0);
      step(r, 1'($urandom), 1'($urandom), 1'($urandom), st, fe,
           allocated_mask() & $urandom & $urandom, fl);
    end
    idle();
    idle();

    // Bounded drain of outstanding expectations.
    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
